// File: rtl/msg_pkg.sv
// Shared constants and types for the message reorder/stream path.
package msg_pkg;

   // Reorder modes, sampled together with a load. 2'b11 behaves as pass.
   localparam logic [1:0] MODE_PASS     = 2'b00;
   localparam logic [1:0] MODE_BYTE_REV = 2'b01;
   localparam logic [1:0] MODE_BIT_REV  = 2'b10;

   // Terminator characters appended after the payload.
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DATA    = 2'd1,
      TERM_LF = 2'd2,
      TERM_CR = 2'd3
   } state_t;

   // Mirror a byte: bit 0 becomes bit 7 and so on.
   function automatic logic [7:0] bitrev8(input logic [7:0] b);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

endpackage

// File: rtl/msg_reverse_streamer_if.sv
// Load handshake plus byte stream between producer, streamer and printer.
//
// Handshakes: load is accepted on a rising edge where load && load_ready;
// a byte moves on a rising edge where tx_valid && tx_ready. Once tx_valid
// is raised, tx_data and tx_valid hold until the byte moves (reset aside),
// and tx_valid never depends combinationally on tx_ready.
interface msg_reverse_streamer_if
   import msg_pkg::*;
#(
   parameter int NUM_BYTES = 8
);
   logic                     load;
   logic                     load_ready;
   logic [8*NUM_BYTES-1:0]   bits_in;
   logic [1:0]               mode;
   logic [7:0]               tx_data;
   logic                     tx_valid;
   logic                     tx_ready;
   logic                     busy;
   logic                     msg_done;
   state_t                   dbg_state;

   modport master (
      output load, bits_in, mode, tx_ready,
      input  load_ready, tx_data, tx_valid, busy, msg_done, dbg_state
   );

   modport slave (
      input  load, bits_in, mode, tx_ready,
      output load_ready, tx_data, tx_valid, busy, msg_done, dbg_state
   );
endinterface

// File: rtl/msg_reorder.sv
// Combinational reorder of an N-byte word into emission order:
// output byte i is the i-th byte to be sent.
module msg_reorder
   import msg_pkg::*;
#(
   parameter int NUM_BYTES = 8
) (
   input  logic [8*NUM_BYTES-1:0] word,
   input  logic [1:0]             mode,
   output logic [8*NUM_BYTES-1:0] reordered
);

   // Select source byte per output slot; unknown mode falls back to pass.
   always_comb begin
      reordered = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         case (mode)
            MODE_BYTE_REV: reordered[8*i +: 8] = word[8*i +: 8];
            MODE_BIT_REV:  reordered[8*i +: 8] = bitrev8(word[8*i +: 8]);
            default:       reordered[8*i +: 8] = word[8*(NUM_BYTES-1-i) +: 8];
         endcase
      end
   end

endmodule

// File: rtl/msg_reverse_streamer.sv
// Captures an N-byte word, reorders it and streams it byte by byte,
// optionally followed by LF/CR, over a valid/ready handshake.
module msg_reverse_streamer
   import msg_pkg::*;
#(
   parameter int NUM_BYTES      = 8,
   parameter bit APPEND_NEWLINE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   msg_reverse_streamer_if.slave   bus
);

   localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

   generate
      if (NUM_BYTES < 1 || NUM_BYTES > 32) begin : g_bad_num_bytes
         $error("msg_reverse_streamer: NUM_BYTES must be in 1..32");
      end
   endgenerate

   state_t                 state;
   logic [CW-1:0]          count;
   logic [7:0]             buffer [NUM_BYTES];
   logic [8*NUM_BYTES-1:0] reordered;
   logic                   xfer;
   logic [CW-1:0]          next_count;

   msg_reorder #(.NUM_BYTES(NUM_BYTES)) u_reorder (
      .word      (bus.bits_in),
      .mode      (bus.mode),
      .reordered (reordered)
   );

   assign xfer           = bus.tx_valid && bus.tx_ready;
   assign next_count     = count + CW'(1);
   assign bus.load_ready = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.dbg_state  = state;

   // Stream FSM: capture on load, advance one byte per transfer, finish with terminators.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         bus.tx_data  <= 8'h00;
         bus.tx_valid <= 1'b0;
         bus.msg_done <= 1'b0;
         for (int k = 0; k < NUM_BYTES; k++) buffer[k] <= 8'h00;
      end else begin
         bus.msg_done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load) begin
                  for (int k = 0; k < NUM_BYTES; k++) buffer[k] <= reordered[8*k +: 8];
                  bus.tx_data  <= reordered[7:0];
                  bus.tx_valid <= 1'b1;
                  count        <= '0;
                  state        <= DATA;
               end
            end
            DATA: begin
               if (xfer) begin
                  if (count == LAST_IDX) begin
                     count <= '0;
                     if (APPEND_NEWLINE) begin
                        bus.tx_data <= ASCII_LF;
                        state       <= TERM_LF;
                     end else begin
                        bus.tx_data  <= 8'h00;
                        bus.tx_valid <= 1'b0;
                        bus.msg_done <= 1'b1;
                        state        <= IDLE;
                     end
                  end else begin
                     count       <= next_count;
                     bus.tx_data <= buffer[next_count];
                  end
               end
            end
            TERM_LF: begin
               if (xfer) begin
                  bus.tx_data <= ASCII_CR;
                  state       <= TERM_CR;
               end
            end
            TERM_CR: begin
               if (xfer) begin
                  bus.tx_data  <= 8'h00;
                  bus.tx_valid <= 1'b0;
                  bus.msg_done <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_msg_reverse_streamer.sv
// Directed bench: 8-byte streamer with terminators and 4-byte without.
module tb_msg_reverse_streamer;
   import msg_pkg::*;

   logic clk;
   logic rst;

   int n_checks;
   int n_errors;

   logic [7:0] exp_q[$];

   msg_reverse_streamer_if #(.NUM_BYTES(8)) bus_a ();
   msg_reverse_streamer_if #(.NUM_BYTES(4)) bus_b ();

   msg_reverse_streamer #(.NUM_BYTES(8), .APPEND_NEWLINE(1'b1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   msg_reverse_streamer #(.NUM_BYTES(4), .APPEND_NEWLINE(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push8(input logic [63:0] bytes_msb_first);
      logic [63:0] v;
      v = bytes_msb_first;
      for (int i = 7; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
   endtask

   // Load dut_a at the next edge; returns at the negedge after acceptance.
   task automatic load_a(input logic [63:0] word, input logic [1:0] m);
      @(negedge clk);
      check("a_load_ready_idle", 32'(bus_a.load_ready), 32'd1);
      bus_a.load    = 1'b1;
      bus_a.bits_in = word;
      bus_a.mode    = m;
      @(negedge clk);
      bus_a.load = 1'b0;
   endtask

   // Walk the expected stream on dut_a, with optional stall and foreign loads.
   task automatic stream_a(input int stall_at, input int stall_len, input bit inject_load);
      int n;
      logic [7:0] b;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         b = exp_q[0];
         if (inject_load) begin
            bus_a.load    = 1'b1;
            bus_a.bits_in = '1;
         end
         if (i == stall_at) begin
            bus_a.tx_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               @(negedge clk);
               check("a_stall_valid", 32'(bus_a.tx_valid), 32'd1);
               check("a_stall_data", 32'(bus_a.tx_data), 32'(b));
            end
            bus_a.tx_ready = 1'b1;
         end
         check("a_valid", 32'(bus_a.tx_valid), 32'd1);
         check("a_data", 32'(bus_a.tx_data), 32'(b));
         check("a_load_ready_busy", 32'(bus_a.load_ready), 32'd0);
         check("a_busy", 32'(bus_a.busy), 32'd1);
         void'(exp_q.pop_front());
         @(negedge clk);
      end
      bus_a.load = 1'b0;
      check("a_msg_done", 32'(bus_a.msg_done), 32'd1);
      check("a_valid_end", 32'(bus_a.tx_valid), 32'd0);
      check("a_data_end", 32'(bus_a.tx_data), 32'd0);
      check("a_load_ready_end", 32'(bus_a.load_ready), 32'd1);
      @(negedge clk);
      check("a_msg_done_pulse", 32'(bus_a.msg_done), 32'd0);
      check("a_idle_valid", 32'(bus_a.tx_valid), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus_a.load = 1'b0; bus_a.bits_in = '0; bus_a.mode = 2'b00; bus_a.tx_ready = 1'b1;
      bus_b.load = 1'b0; bus_b.bits_in = '0; bus_b.mode = 2'b00; bus_b.tx_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values
      check("rst_valid", 32'(bus_a.tx_valid), 32'd0);
      check("rst_data", 32'(bus_a.tx_data), 32'd0);
      check("rst_busy", 32'(bus_a.busy), 32'd0);
      check("rst_done", 32'(bus_a.msg_done), 32'd0);
      check("rst_load_ready", 32'(bus_a.load_ready), 32'd1);
      check("rst_b_valid", 32'(bus_b.tx_valid), 32'd0);
      rst = 1'b0;

      // Pass mode, full terminator sequence
      push8(64'h0123456789ABCDEF); exp_q.push_back(8'h0A); exp_q.push_back(8'h0D);
      load_a(64'h0123456789ABCDEF, 2'b00);
      stream_a(-1, 0, 1'b0);

      // Byte-reverse
      push8(64'hEFCDAB8967452301); exp_q.push_back(8'h0A); exp_q.push_back(8'h0D);
      load_a(64'h0123456789ABCDEF, 2'b01);
      stream_a(-1, 0, 1'b0);

      // Bit-reverse
      push8(64'hF7B3D591E6A2C480); exp_q.push_back(8'h0A); exp_q.push_back(8'h0D);
      load_a(64'h0123456789ABCDEF, 2'b10);
      stream_a(-1, 0, 1'b0);

      // Mode 11 behaves as pass
      push8(64'h1122334455667788); exp_q.push_back(8'h0A); exp_q.push_back(8'h0D);
      load_a(64'h1122334455667788, 2'b11);
      stream_a(-1, 0, 1'b0);

      // Backpressure on the second byte for 3 cycles
      push8(64'h0123456789ABCDEF); exp_q.push_back(8'h0A); exp_q.push_back(8'h0D);
      load_a(64'h0123456789ABCDEF, 2'b00);
      stream_a(1, 3, 1'b0);

      // Backpressure on the LF terminator
      push8(64'h0123456789ABCDEF); exp_q.push_back(8'h0A); exp_q.push_back(8'h0D);
      load_a(64'h0123456789ABCDEF, 2'b00);
      stream_a(8, 2, 1'b0);

      // Loads during an active message are ignored
      push8(64'h0123456789ABCDEF); exp_q.push_back(8'h0A); exp_q.push_back(8'h0D);
      load_a(64'h0123456789ABCDEF, 2'b00);
      stream_a(-1, 0, 1'b1);

      // Reset after three transfers aborts the message
      load_a(64'h0123456789ABCDEF, 2'b00);
      check("r_b0", 32'(bus_a.tx_data), 32'h01);
      @(negedge clk);
      check("r_b1", 32'(bus_a.tx_data), 32'h23);
      @(negedge clk);
      check("r_b2", 32'(bus_a.tx_data), 32'h45);
      @(negedge clk);
      check("r_b3", 32'(bus_a.tx_data), 32'h67);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("r_valid", 32'(bus_a.tx_valid), 32'd0);
      check("r_data", 32'(bus_a.tx_data), 32'd0);
      check("r_busy", 32'(bus_a.busy), 32'd0);
      check("r_load_ready", 32'(bus_a.load_ready), 32'd1);
      check("r_done", 32'(bus_a.msg_done), 32'd0);
      @(negedge clk);
      check("r_done_after", 32'(bus_a.msg_done), 32'd0);
      check("r_state", 32'(bus_a.dbg_state), 32'(IDLE));
      exp_q.delete();
      push8(64'h0123456789ABCDEF); exp_q.push_back(8'h0A); exp_q.push_back(8'h0D);
      load_a(64'h0123456789ABCDEF, 2'b00);
      stream_a(-1, 0, 1'b0);

      // 4-byte, no terminator, back-to-back loads
      @(negedge clk);
      bus_b.load = 1'b1; bus_b.bits_in = 32'hDEADBEEF; bus_b.mode = 2'b01;
      @(negedge clk);
      bus_b.load = 1'b0;
      exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
      exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
      for (int i = 0; i < 4; i++) begin
         check("b_valid", 32'(bus_b.tx_valid), 32'd1);
         check("b_data", 32'(bus_b.tx_data), 32'(exp_q.pop_front()));
         @(negedge clk);
      end
      check("b_msg_done", 32'(bus_b.msg_done), 32'd1);
      check("b_valid_end", 32'(bus_b.tx_valid), 32'd0);
      check("b_load_ready", 32'(bus_b.load_ready), 32'd1);
      bus_b.load = 1'b1; bus_b.bits_in = 32'h12345678; bus_b.mode = 2'b10;
      @(negedge clk);
      bus_b.load = 1'b0;
      check("b_done_pulse", 32'(bus_b.msg_done), 32'd0);
      exp_q.push_back(8'h1E); exp_q.push_back(8'h6A);
      exp_q.push_back(8'h2C); exp_q.push_back(8'h48);
      for (int i = 0; i < 4; i++) begin
         check("b2_valid", 32'(bus_b.tx_valid), 32'd1);
         check("b2_data", 32'(bus_b.tx_data), 32'(exp_q.pop_front()));
         @(negedge clk);
      end
      check("b2_msg_done", 32'(bus_b.msg_done), 32'd1);
      check("b2_data_end", 32'(bus_b.tx_data), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
